// File: rtl/hps_image_server.sv
// rtl/hps_image_server.sv - HPS-loadable 8-bit image store serving the copier's rom_addr/rom_data reads
`timescale 1ns/1ps
module hps_image_server #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int DEPTH = IMG_W * IMG_H
) (
  input  logic        clk_50MHz,
  input  logic        vga_reset,
  input  logic        hps_req,
  input  logic [1:0]  hps_cmd,
  input  logic [14:0] hps_addr,
  input  logic [7:0]  hps_wdata,
  output logic        hps_ack,
  output logic        hps_err,
  output logic        img_ready,
  output logic        reload,
  output logic [14:0] wr_count,
  input  logic [14:0] rom_addr,
  output logic [31:0] rom_data
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  state_t      state, state_d;
  logic        s1, s2, req_seen;
  logic [1:0]  cmd_q;
  logic [14:0] addr_q;
  logic [7:0]  wdata_q;
  logic        latch_en, exec_en, ack_en;
  logic        pending, wr_ok, mem_we, rd_in_range;

  logic [7:0]  mem [DEPTH];

  assign pending     = (s2 != req_seen);
  assign wr_ok       = ({1'b0, addr_q} < DEPTH_W) && !img_ready;
  assign mem_we      = exec_en && (cmd_q == CMD_WRITE) && wr_ok;
  assign rd_in_range = ({1'b0, rom_addr} < DEPTH_W);

  always_comb begin
    state_d  = state;
    latch_en = 1'b0;
    exec_en  = 1'b0;
    ack_en   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          latch_en = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        ack_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      req_seen  <= 1'b0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      hps_ack   <= 1'b0;
      hps_err   <= 1'b0;
      img_ready <= 1'b0;
      reload    <= 1'b0;
      wr_count  <= '0;
    end else begin
      state  <= state_d;
      s1     <= hps_req;
      s2     <= s1;
      reload <= exec_en && (cmd_q == CMD_COMMIT);
      if (latch_en) begin
        cmd_q    <= hps_cmd;
        addr_q   <= hps_addr;
        wdata_q  <= hps_wdata;
        req_seen <= s2;
      end
      if (exec_en) begin
        case (cmd_q)
          CMD_WRITE: begin
            if (wr_ok) begin
              if (wr_count != 15'h7FFF) wr_count <= wr_count + 15'd1;
            end else begin
              hps_err <= 1'b1;
            end
          end
          CMD_COMMIT: img_ready <= 1'b1;
          CMD_CLEAR: begin
            img_ready <= 1'b0;
            hps_err   <= 1'b0;
            wr_count  <= '0;
          end
          default: ;
        endcase
      end
      if (ack_en) hps_ack <= ~hps_ack;
    end
  end

  // Pixel memory has no reset so it maps onto block RAM; reset only clears the read register.
  always_ff @(posedge clk_50MHz) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
  end

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) rom_data <= '0;
    else            rom_data <= rd_in_range ? {24'd0, mem[rom_addr[AW-1:0]]} : 32'd0;
  end

endmodule

// File: doc/hps_image_server.md
# hps_image_server

Responder side of the copier's image-source interface: serves `rom_addr` read requests from on-chip pixel memory with registered `rom_data`, and accepts the image from the HPS through a toggle-handshake PIO port. It sits between the HPS lightweight-bridge PIOs and the ROM→framebuffer copier, replacing the static source ROM with a software-loadable 160×120 8-bit image. It also tells the system when a complete image has been committed.

## Interface

**Parameters**
- `IMG_W`, default 160: source image width in pixels.
- `IMG_H`, default 120: source image height in pixels.
- `DEPTH`, default `IMG_W*IMG_H` (19200): number of pixel locations.

**Ports**
- `clk_50MHz` in 1: single clock; all logic is on its rising edge.
- `vga_reset` in 1: reset, asynchronous, active-low.
- `hps_req` in 1: request toggle from the HPS. Every change is one request.
- `hps_cmd` in 2: command.
  - 00 NOP
  - 01 WRITE
  - 10 COMMIT
  - 11 CLEAR
- `hps_addr` in 15: pixel address for WRITE.
- `hps_wdata` in 8: pixel value for WRITE.
- `hps_ack` out 1: acknowledge toggle. It equals `hps_req` once the request has been served.
- `hps_err` out 1: sticky error flag. Cleared only by CLEAR or reset.
- `img_ready` out 1: a committed image is present.
- `reload` out 1: one-cycle pulse on each COMMIT. Restart request for the copier.
- `wr_count` out 15: number of accepted WRITEs since the last CLEAR. Saturates at 32767.
- `rom_addr` in 15: read address from the copier.
- `rom_data` out 32: `{24'd0, pixel}` for the sampled `rom_addr`.

## Operation

**Request synchronization**
- `hps_req` passes through a 2-flop synchronizer (`s1`, `s2`).
- Register `req_seen` holds the last served request value.
- A request is pending when `s2 != req_seen`.

**State machine: IDLE → EXEC → ACK → IDLE**
- **IDLE**
  - No pending request: stay in IDLE.
  - Pending request: latch `hps_cmd`, `hps_addr`, `hps_wdata`; set `req_seen <= s2`; go to EXEC.
- **EXEC:** perform the latched command, then go to ACK.
  - NOP: no effect.
  - WRITE, accepted only when `addr < DEPTH` and `img_ready == 0`:
    - write memory at `addr`;
    - `wr_count <= wr_count + 1`, saturating at 32767.
  - WRITE, rejected (otherwise): set `hps_err`; memory and `wr_count` are unchanged.
  - COMMIT: set `img_ready`; assert `reload` for this one cycle. A repeated COMMIT pulses `reload` again.
  - CLEAR: clear `img_ready`, `hps_err` and `wr_count`. Memory contents are kept.
- **ACK:** `hps_ack <= ~hps_ack`, go to IDLE. Every request is acknowledged, including rejected ones.

**Handshake rules**
- Software sets `hps_cmd`, `hps_addr` and `hps_wdata` stable, then toggles `hps_req`.
- Software waits for `hps_ack == hps_req` before the next request.
- A toggle arriving while in EXEC or ACK is served on return to IDLE, because `s2` is compared with `req_seen`.
- A double toggle inside a single service window cancels out and is not served. Software must not do this.

**Read port**
- `rom_addr` is sampled every cycle; reads are independent of `img_ready` and of the FSM state.
- `rom_addr >= DEPTH` returns 0.
- Read and write to the same address in the same cycle returns the old data (read-before-write).

**Reset (asserted at any time, including mid-request)**
- FSM returns to IDLE.
- Output values: `hps_ack` = 0, `hps_err` = 0, `img_ready` = 0, `reload` = 0, `wr_count` = 0, `rom_data` = 0.
- `req_seen`, `s1` and `s2` reset to 0.
- Memory contents are undefined after power-up and are not cleared by reset.
- If `hps_req` = 1 when reset is released, that counts as one pending request (the NOP idiom).

## Timing

- Edge E0 is the rising edge that first samples the new `hps_req` into `s1`.
  - E1: `s2` updated.
  - E2: IDLE→EXEC, fields latched.
  - E3: memory write, flag and counter updates; `reload` high from E3 to E4.
  - E4: `hps_ack` toggles.
- Request-to-ack latency is 4 cycles after E0. Service throughput is at most one request per 4 cycles after the synchronizer.
- Read latency is 1 cycle: `rom_addr` sampled at edge N gives `rom_data` valid after edge N; back-to-back reads every cycle are supported.
- Arithmetic: address compare is 15-bit unsigned against `DEPTH`; `wr_count` is 15-bit with saturation, with no wrap.

## Test plan

- **Reset and read-after-write:**
  - Stimulus: reset; WRITE `addr=0x0005`, `data=0xA7`; then `rom_addr=5`.
  - Required response: `hps_ack` toggles exactly 4 cycles after E0; `rom_data=0x000000A7` one cycle later; `wr_count=1`.
- **Full load and commit:**
  - Stimulus: 19200 WRITEs with `data=addr[7:0]`, then COMMIT.
  - Required response: `wr_count=19200`; `reload` high for exactly 1 cycle; `img_ready=1`; readback of address 19199 gives `0x000000FF`.
- **Out-of-range WRITE:**
  - Stimulus: WRITE `addr=19200`.
  - Required response: `hps_err=1`; ack still toggles; `wr_count` unchanged; `rom_addr=19200` reads 0.
- **WRITE after COMMIT, then CLEAR:**
  - Stimulus: WRITE while `img_ready=1`, then CLEAR.
  - Required response: the WRITE is rejected with `hps_err=1` and the memory word unchanged; CLEAR gives `img_ready=0`, `hps_err=0`, `wr_count=0`.
- **Toggle while busy:**
  - Stimulus: toggle `hps_req` during EXEC.
  - Required response: the second request is served right after the first; ack toggles twice in total.
- **Reset mid-request and read/write collision:**
  - Stimulus: assert `vga_reset` at E3.
  - Required response: all outputs return to their reset values asynchronously; FSM is in IDLE.
  - Stimulus: same-cycle read and write at address 10 (old value `0x11`, new value `0x22`).
  - Required response: `rom_data=0x11`, then `0x22` on the next read.
